bsg_fpu_denorm_norm: RTL and testbench

BSG_FPU_DENORM_NORM -- requirements
Module: bsg_fpu_denorm_norm

---
 rtl/bsg_fpu_denorm_norm.sv | 91 +++++++++
 tb/tb_bsg_fpu_denorm_norm.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bsg_fpu_denorm_norm.sv
// bsg_fpu_denorm_norm: normalizes an unpacked FP operand so the mantissa carries an explicit leading one
// Ports: clk_i, reset_n_i (async active-low); v_i/ready_o operand handshake; sign_i, exp_i, man_i and
//   zero_i/nan_i/sig_nan_i/infty_i/denormal_i operand in; v_o/yumi_i result handshake; sign_o,
//   exp_o (signed, e_p+2 bits), man_o (hidden bit at m_p) and registered class flags out.
// Build option: define BSG_FPU_DENORM_FAST_EN to normalize denormals in a single cycle.
module bsg_fpu_denorm_norm #(
   parameter int e_p = 5,
   parameter int m_p = 10
) (
   input  logic           clk_i,
   input  logic           reset_n_i,
   input  logic           v_i,
   output logic           ready_o,
   input  logic           sign_i,
   input  logic [e_p-1:0] exp_i,
   input  logic [m_p-1:0] man_i,
   input  logic           zero_i,
   input  logic           nan_i,
   input  logic           sig_nan_i,
   input  logic           infty_i,
   input  logic           denormal_i,
   output logic           v_o,
   input  logic           yumi_i,
   output logic           sign_o,
   output logic [e_p+1:0] exp_o,
   output logic [m_p:0]   man_o,
   output logic           zero_o,
   output logic           nan_o,
   output logic           sig_nan_o,
   output logic           infty_o,
   output logic           denormal_o
);
   localparam int cw = $clog2(m_p + 1);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t         state_r, state_n;
   logic [cw-1:0]  cnt_r;
   logic [m_p:0]   man_r, man_sh, man_ld;
   logic [e_p+1:0] exp_r, exp_ld;
   logic           accept, go_shift, shift_done;
   assign ready_o = state_r == IDLE;
   assign v_o = state_r == DONE;
   assign accept = v_i & ready_o;
   assign man_o = man_r;
   assign exp_o = exp_r;
   assign man_sh = man_r << 1;
   // the count cap stops an all-zero denormal mantissa from shifting forever
   assign shift_done = man_sh[m_p] | (cnt_r == cw'(m_p - 1));
`ifdef BSG_FPU_DENORM_FAST_EN
   int k;
   always_comb begin
      // k: left shifts needed to bring the leading one up to bit m_p (m_p for a zero mantissa)
      k = m_p;
      for (int i = 0; i < m_p; i++) if (man_i[i]) k = m_p - i;
      go_shift = 1'b0;
      man_ld = zero_i ? '0 : denormal_i ? {1'b0, man_i} << k : {1'b1, man_i};
      exp_ld = zero_i ? '0 : denormal_i ? (e_p+2)'(1 - k) : {2'b00, exp_i};
   end
`else
   assign go_shift = denormal_i & ~zero_i;
   assign man_ld = zero_i ? '0 : {~denormal_i, man_i};
   assign exp_ld = zero_i ? '0 : denormal_i ? (e_p+2)'(1) : {2'b00, exp_i};
`endif
   always_comb begin
      state_n = state_r;
      case (state_r)
         IDLE:    state_n = accept ? (go_shift ? SHIFT : DONE) : IDLE;
         SHIFT:   state_n = shift_done ? DONE : SHIFT;
         DONE:    state_n = yumi_i ? IDLE : DONE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) state_r <= IDLE;
      else state_r <= state_n;
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         cnt_r <= '0;
         man_r <= '0;
         exp_r <= '0;
         {sign_o, zero_o, nan_o, sig_nan_o, infty_o, denormal_o} <= '0;
      end else if (accept) begin
         cnt_r <= '0;
         man_r <= man_ld;
         exp_r <= exp_ld;
         {sign_o, zero_o, nan_o, sig_nan_o, infty_o, denormal_o} <= {sign_i, zero_i, nan_i, sig_nan_i, infty_i, denormal_i};
      end else if (state_r == SHIFT) begin
         cnt_r <= cnt_r + cw'(1);
         man_r <= man_sh;
         exp_r <= exp_r - (e_p+2)'(1);
      end
endmodule

// File: tb/tb_bsg_fpu_denorm_norm.sv
// tb_bsg_fpu_denorm_norm: self-checking bench for bsg_fpu_denorm_norm against an arithmetic reference model
module tb_bsg_fpu_denorm_norm;
   localparam int E = 5;
   localparam int M = 10;
   logic clk = 1'b0;
   logic reset_n_i = 1'b0;
   logic v_i = 1'b0;
   logic yumi_i = 1'b0;
   logic sign_i = 1'b0;
   logic [E-1:0] exp_i = '0;
   logic [M-1:0] man_i = '0;
   logic zero_i = 1'b0, nan_i = 1'b0, sig_nan_i = 1'b0, infty_i = 1'b0, denormal_i = 1'b0;
   logic ready_o, v_o, sign_o, zero_o, nan_o, sig_nan_o, infty_o, denormal_o;
   logic [E+1:0] exp_o;
   logic [M:0] man_o;
   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   bsg_fpu_denorm_norm #(.e_p(E), .m_p(M)) dut (
      .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o),
      .sign_i(sign_i), .exp_i(exp_i), .man_i(man_i),
      .zero_i(zero_i), .nan_i(nan_i), .sig_nan_i(sig_nan_i), .infty_i(infty_i), .denormal_i(denormal_i),
      .v_o(v_o), .yumi_i(yumi_i), .sign_o(sign_o), .exp_o(exp_o), .man_o(man_o),
      .zero_o(zero_o), .nan_o(nan_o), .sig_nan_o(sig_nan_o), .infty_o(infty_o), .denormal_o(denormal_o)
   );

   // f = {zero, nan, sig_nan, infty, denormal}; denormals are doubled until they reach 2^M
   function automatic void model(input logic [4:0] f, input logic [E-1:0] e, input logic [M-1:0] m,
                                 output logic [M:0] xm, output logic [E+1:0] xe, output int lat);
      int v, k;
      lat = 1;
      if (f[4]) begin
         xm = '0;
         xe = '0;
      end else if (f[0]) begin
         v = int'(m);
         k = 0;
         while (v < (1 << M) && k < M) begin
            v = v * 2;
            k++;
         end
         xm = (v >= (1 << M)) ? (M+1)'(v) : '0;
         xe = (E+2)'(1 - k);
`ifndef BSG_FPU_DENORM_FAST_EN
         lat = k + 1;
`endif
      end else begin
         xm = {1'b1, m};
         xe = {2'b00, e};
      end
   endfunction

   task automatic run_op(input string nm, input logic s, input logic [E-1:0] e, input logic [M-1:0] m, input logic [4:0] f);
      logic [M:0] xm;
      logic [E+1:0] xe;
      int lat, n;
      model(f, e, m, xm, xe, lat);
      sign_i = s; exp_i = e; man_i = m;
      {zero_i, nan_i, sig_nan_i, infty_i, denormal_i} = f;
      v_i = 1'b1;
      @(posedge clk);
      #1 v_i = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!v_o && n < 40);
      total++;
      if (!v_o || n != lat) $display("FAIL %s latency: got %0d (v_o=%b) expected %0d", nm, n, v_o, lat);
      else passed++;
      total++;
      if (man_o !== xm) $display("FAIL %s man_o: got %h expected %h", nm, man_o, xm);
      else passed++;
      total++;
      if (exp_o !== xe) $display("FAIL %s exp_o: got %h expected %h", nm, exp_o, xe);
      else passed++;
      total++;
      if ({sign_o, zero_o, nan_o, sig_nan_o, infty_o, denormal_o} !== {s, f})
         $display("FAIL %s flags: got %b expected %b", nm, {sign_o, zero_o, nan_o, sig_nan_o, infty_o, denormal_o}, {s, f});
      else passed++;
      total++;
      if (ready_o !== 1'b0) $display("FAIL %s ready_in_done: got %b expected 0", nm, ready_o);
      else passed++;
      yumi_i = 1'b1;
      @(posedge clk);
      #1 yumi_i = 1'b0;
      @(negedge clk);
      total++;
      if (v_o !== 1'b0 || ready_o !== 1'b1) $display("FAIL %s release: got v_o=%b ready_o=%b expected 0 1", nm, v_o, ready_o);
      else passed++;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++;
      if ({v_o, ready_o, sign_o, zero_o, nan_o, sig_nan_o, infty_o, denormal_o, exp_o, man_o} !== {2'b01, 24'd0})
         $display("FAIL reset_state: got v=%b rdy=%b flags=%b exp=%h man=%h expected 0 1 0 0 0",
                  v_o, ready_o, {sign_o, zero_o, nan_o, sig_nan_o, infty_o, denormal_o}, exp_o, man_o);
      else passed++;
      reset_n_i = 1'b1;
   endtask

   task automatic test_directed();
      run_op("normal_3c00", 1'b0, 5'd15, 10'h000, 5'b00000);
      run_op("denorm_200", 1'b0, 5'd0, 10'h200, 5'b00001);
      run_op("denorm_001", 1'b0, 5'd0, 10'h001, 5'b00001);
      run_op("zero_8000", 1'b1, 5'd0, 10'h000, 5'b10000);
      run_op("snan_7c01", 1'b0, 5'd31, 10'h001, 5'b01100);
      run_op("qnan_7e00", 1'b0, 5'd31, 10'h200, 5'b01000);
      run_op("neg_inf", 1'b1, 5'd31, 10'h000, 5'b00010);
      run_op("denorm_man0", 1'b0, 5'd0, 10'h000, 5'b00001);
   endtask

   task automatic test_random();
      for (int i = 0; i < 25; i++) begin
         int c;
         logic s;
         logic [E-1:0] e;
         logic [M-1:0] m;
         logic [4:0] f;
         c = $urandom_range(0, 4);
         s = 1'($urandom);
         m = M'($urandom);
         case (c)
            0: begin e = E'($urandom_range(1, 15)); f = 5'b00000; end
            1: begin e = '0; m = '0; f = 5'b10000; end
            2: begin e = '1; m = '0; f = 5'b00010; end
            3: begin e = '1; if (m == '0) m = 1; f = {2'b01, ~m[M-1], 2'b00}; end
            default: begin e = '0; m = m >> $urandom_range(0, M - 1); if (m == '0) m = 1; f = 5'b00001; end
         endcase
         run_op("random", s, e, m, f);
      end
   endtask

   task automatic test_hold();
      sign_i = 1'b0; exp_i = 5'd15; man_i = 10'h155;
      {zero_i, nan_i, sig_nan_i, infty_i, denormal_i} = 5'b00000;
      v_i = 1'b1;
      @(posedge clk);
      #1 sign_i = 1'b1; exp_i = 5'd3; man_i = 10'h3ff;
      @(negedge clk);
      total++;
      if (v_o !== 1'b1) $display("FAIL hold_valid: got %b expected 1", v_o);
      else passed++;
      repeat (5) begin
         @(negedge clk);
         total++;
         if (v_o !== 1'b1 || ready_o !== 1'b0 || man_o !== 11'h555 || exp_o !== 7'd15 || sign_o !== 1'b0)
            $display("FAIL hold_stable: got v=%b rdy=%b man=%h exp=%h sign=%b expected 1 0 555 0f 0", v_o, ready_o, man_o, exp_o, sign_o);
         else passed++;
      end
      yumi_i = 1'b1;
      v_i = 1'b0;
      @(posedge clk);
      #1 yumi_i = 1'b0;
      @(negedge clk);
      total++;
      if (v_o !== 1'b0 || ready_o !== 1'b1) $display("FAIL hold_release: got v_o=%b ready_o=%b expected 0 1", v_o, ready_o);
      else passed++;
   endtask

   task automatic test_reset_mid_shift();
      int n;
      sign_i = 1'b0; exp_i = '0; man_i = 10'h001;
      {zero_i, nan_i, sig_nan_i, infty_i, denormal_i} = 5'b00001;
      v_i = 1'b1;
      @(posedge clk);
      #1 v_i = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset_n_i = 1'b0;
      #1;
      total++;
      if (v_o !== 1'b0 || ready_o !== 1'b1 || man_o !== '0 || exp_o !== '0)
         $display("FAIL midshift_reset: got v=%b rdy=%b man=%h exp=%h expected 0 1 0 0", v_o, ready_o, man_o, exp_o);
      else passed++;
      @(negedge clk);
      reset_n_i = 1'b1;
      n = 0;
      repeat (15) begin
         @(negedge clk);
         if (v_o) n++;
      end
      total++;
      if (n != 0) $display("FAIL midshift_no_output: got %0d valid cycles expected 0", n);
      else passed++;
      run_op("after_reset", 1'b1, 5'd7, 10'h0a5, 5'b00000);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_hold();
      test_random();
      test_reset_mid_shift();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
